// File: rtl/count_sequence_checker_pkg.sv
// Shared encodings and default widths for the count sequence checker.
package count_sequence_checker_pkg;

   localparam int unsigned CNT_W_DEF    = 4;
   localparam int unsigned WRAP_W_DEF   = 8;
   localparam int unsigned ERR_W_DEF    = 8;
   localparam int unsigned SYNC_LEN_DEF = 2;
   localparam int unsigned RUN_W        = 4;
   localparam int unsigned ST_W         = 2;

   localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
   localparam logic [ST_W-1:0] ST_SYNC   = 2'd1;
   localparam logic [ST_W-1:0] ST_LOCKED = 2'd2;
   localparam logic [ST_W-1:0] ST_ERROR  = 2'd3;

endpackage

// File: rtl/count_sequence_checker_seq_step_compare.sv
// Combinational step classifier: expected next count and how the new sample relates to it.
module seq_step_compare #(
   parameter int unsigned CNT_W = 4
) (
   input  logic [CNT_W-1:0] prev,
   input  logic [CNT_W-1:0] cnt_in,
   output logic [CNT_W-1:0] exp,
   output logic             match,
   output logic             wrap,
   output logic             rst_evt
);

   assign exp     = prev + CNT_W'(1);
   assign match   = (cnt_in == exp);
   assign wrap    = match & (prev == {CNT_W{1'b1}});
   assign rst_evt = (cnt_in == CNT_W'(0)) & ~match;

endmodule

// File: rtl/count_sequence_checker.sv
// Passive monitor confirming an upstream counter advances by +1 per valid sample.
// Optional mismatch capture ports enabled by COUNT_SEQUENCE_CHECKER_CAPTURE_EN.
module count_sequence_checker
   import count_sequence_checker_pkg::*;
#(
   parameter int unsigned CNT_W    = CNT_W_DEF,
   parameter int unsigned WRAP_W   = WRAP_W_DEF,
   parameter int unsigned ERR_W    = ERR_W_DEF,
   parameter int unsigned SYNC_LEN = SYNC_LEN_DEF
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [CNT_W-1:0]  cnt_in,
   input  logic              cnt_valid,
   input  logic              clr,
   output logic              locked,
   output logic              err,
   output logic              restart,
   output logic [WRAP_W-1:0] wrap_cnt,
   output logic [ERR_W-1:0]  err_cnt
`ifdef COUNT_SEQUENCE_CHECKER_CAPTURE_EN
   ,
   output logic [CNT_W-1:0]  cap_exp,
   output logic [CNT_W-1:0]  cap_act
`endif
);

   logic [ST_W-1:0]   state_q, state_d;
   logic [CNT_W-1:0]  prev_q, prev_d;
   logic [RUN_W-1:0]  good_run_q, good_run_d;
   logic              locked_q, locked_d;
   logic              err_q, err_d;
   logic              restart_q, restart_d;
   logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
   logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0]  cap_exp_q, cap_exp_d;
   logic [CNT_W-1:0]  cap_act_q, cap_act_d;

   logic [CNT_W-1:0]  step_exp;
   logic              step_match;
   logic              step_wrap;
   logic              step_rst_evt;

   seq_step_compare #(
      .CNT_W (CNT_W)
   ) u_step (
      .prev    (prev_q),
      .cnt_in  (cnt_in),
      .exp     (step_exp),
      .match   (step_match),
      .wrap    (step_wrap),
      .rst_evt (step_rst_evt)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         prev_q     <= '0;
         good_run_q <= '0;
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
         restart_q  <= 1'b0;
         wrap_cnt_q <= '0;
         err_cnt_q  <= '0;
         cap_exp_q  <= '0;
         cap_act_q  <= '0;
      end else begin
         state_q    <= state_d;
         prev_q     <= prev_d;
         good_run_q <= good_run_d;
         locked_q   <= locked_d;
         err_q      <= err_d;
         restart_q  <= restart_d;
         wrap_cnt_q <= wrap_cnt_d;
         err_cnt_q  <= err_cnt_d;
         cap_exp_q  <= cap_exp_d;
         cap_act_q  <= cap_act_d;
      end
   end

   // Next-state and status update; clr wins over any sample in the same cycle.
   always_comb begin
      state_d    = state_q;
      prev_d     = prev_q;
      good_run_d = good_run_q;
      locked_d   = 1'b0;
      err_d      = err_q;
      restart_d  = 1'b0;
      wrap_cnt_d = wrap_cnt_q;
      err_cnt_d  = err_cnt_q;
      cap_exp_d  = cap_exp_q;
      cap_act_d  = cap_act_q;

      if (clr) begin
         state_d    = ST_IDLE;
         good_run_d = '0;
         err_d      = 1'b0;
         wrap_cnt_d = '0;
         err_cnt_d  = '0;
         cap_exp_d  = '0;
         cap_act_d  = '0;
      end else if (cnt_valid) begin
         prev_d = cnt_in;
         case (state_q)
            ST_IDLE: begin
               state_d    = ST_SYNC;
               good_run_d = '0;
            end
            ST_SYNC: begin
               if (step_match) begin
                  good_run_d = good_run_q + RUN_W'(1);
                  if ((good_run_q + RUN_W'(1)) == RUN_W'(SYNC_LEN)) begin
                     state_d = ST_LOCKED;
                  end
               end else begin
                  good_run_d = '0;
               end
            end
            ST_LOCKED: begin
               if (step_match) begin
                  if (step_wrap && (wrap_cnt_q != {WRAP_W{1'b1}})) begin
                     wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
                  end
               end else if (step_rst_evt) begin
                  // Upstream counter restarted: resynchronise without flagging an error.
                  restart_d  = 1'b1;
                  state_d    = ST_SYNC;
                  good_run_d = '0;
               end else begin
                  state_d   = ST_ERROR;
                  err_d     = 1'b1;
                  cap_exp_d = step_exp;
                  cap_act_d = cnt_in;
                  if (err_cnt_q != {ERR_W{1'b1}}) begin
                     err_cnt_d = err_cnt_q + ERR_W'(1);
                  end
               end
            end
            default: begin
               if (!step_match && (err_cnt_q != {ERR_W{1'b1}})) begin
                  err_cnt_d = err_cnt_q + ERR_W'(1);
               end
            end
         endcase
      end

      locked_d = (state_d == ST_LOCKED);
   end

   assign locked   = locked_q;
   assign err      = err_q;
   assign restart  = restart_q;
   assign wrap_cnt = wrap_cnt_q;
   assign err_cnt  = err_cnt_q;

`ifdef COUNT_SEQUENCE_CHECKER_CAPTURE_EN
   assign cap_exp = cap_exp_q;
   assign cap_act = cap_act_q;
`else
   // Capture registers have no readers in this build; fold them away.
   logic unused_capture;
   assign unused_capture = ^{cap_exp_q, cap_act_q};
`endif

endmodule

// File: tb/tb_count_sequence_checker.sv
// Directed self-checking bench for count_sequence_checker.
module tb_count_sequence_checker;

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned WRAP_W = 8;
   localparam int unsigned ERR_W  = 8;

   logic              clk;
   logic              rstn;
   logic [CNT_W-1:0]  cnt_in;
   logic              cnt_valid;
   logic              clr;
   logic              locked;
   logic              err;
   logic              restart;
   logic [WRAP_W-1:0] wrap_cnt;
   logic [ERR_W-1:0]  err_cnt;
`ifdef COUNT_SEQUENCE_CHECKER_CAPTURE_EN
   logic [CNT_W-1:0]  cap_exp;
   logic [CNT_W-1:0]  cap_act;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   count_sequence_checker #(
      .CNT_W    (CNT_W),
      .WRAP_W   (WRAP_W),
      .ERR_W    (ERR_W),
      .SYNC_LEN (2)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .cnt_in    (cnt_in),
      .cnt_valid (cnt_valid),
      .clr       (clr),
      .locked    (locked),
      .err       (err),
      .restart   (restart),
      .wrap_cnt  (wrap_cnt),
      .err_cnt   (err_cnt)
`ifdef COUNT_SEQUENCE_CHECKER_CAPTURE_EN
      ,
      .cap_exp   (cap_exp),
      .cap_act   (cap_act)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One cycle of stimulus; outputs are sampled 1 time unit after the capturing edge.
   task automatic step(input logic [CNT_W-1:0] v, input logic vld, input logic c);
      @(negedge clk);
      cnt_in    = v;
      cnt_valid = vld;
      clr       = c;
      @(posedge clk);
      #1;
      cnt_valid = 1'b0;
      clr       = 1'b0;
   endtask

   task automatic feed(input logic [CNT_W-1:0] v);
      step(v, 1'b1, 1'b0);
   endtask

   task automatic feed_run(input int first, input int n);
      for (int i = 0; i < n; i++) feed(CNT_W'((first + i) % 16));
   endtask

   task automatic test_reset();
      rstn = 1'b0; cnt_in = '0; cnt_valid = 1'b0; clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({locked, err, restart, wrap_cnt, err_cnt} !== 19'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %b required 0", {locked, err, restart, wrap_cnt, err_cnt});
      end
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_lock();
      feed(4'd0);
      feed(4'd1);
      n_cmp++;
      if (locked !== 1'b0) begin n_bad++; $display("FAIL lock_early: got %b required 0", locked); end
      feed(4'd2);
      n_cmp++;
      if (locked !== 1'b1) begin n_bad++; $display("FAIL lock_after_2: got %b required 1", locked); end
      n_cmp++;
      if ({err, err_cnt} !== 9'd0) begin n_bad++; $display("FAIL lock_no_err: got %0d/%0d required 0/0", err, err_cnt); end
   endtask

   task automatic test_wrap();
      feed_run(3, 13);
      n_cmp++;
      if (wrap_cnt !== 8'd0) begin n_bad++; $display("FAIL wrap_before: got %0d required 0", wrap_cnt); end
      feed(4'd0);
      n_cmp++;
      if (wrap_cnt !== 8'd1) begin n_bad++; $display("FAIL wrap_first: got %0d required 1", wrap_cnt); end
      feed_run(1, 32);
      n_cmp++;
      if (wrap_cnt !== 8'd3) begin n_bad++; $display("FAIL wrap_three: got %0d required 3", wrap_cnt); end
      n_cmp++;
      if ({locked, err, err_cnt} !== 10'b10_0000_0000) begin
         n_bad++; $display("FAIL wrap_state: got locked=%b err=%b err_cnt=%0d required 1/0/0", locked, err, err_cnt);
      end
   endtask

   task automatic test_restart();
      feed_run(1, 9);
      feed(4'd0);
      n_cmp++;
      if ({restart, locked, err} !== 3'b100) begin
         n_bad++; $display("FAIL restart_pulse: got restart/locked/err=%b required 100", {restart, locked, err});
      end
      feed(4'd1);
      n_cmp++;
      if ({restart, locked} !== 2'b00) begin n_bad++; $display("FAIL restart_width: got %b required 00", {restart, locked}); end
      feed(4'd2);
      n_cmp++;
      if ({locked, err, wrap_cnt} !== {1'b1, 1'b0, 8'd3}) begin
         n_bad++; $display("FAIL relock: got locked=%b err=%b wrap=%0d required 1/0/3", locked, err, wrap_cnt);
      end
   endtask

   task automatic test_error();
      feed(4'd3); feed(4'd4); feed(4'd5); feed(4'd7);
      n_cmp++;
      if ({err, locked, err_cnt} !== {1'b1, 1'b0, 8'd1}) begin
         n_bad++; $display("FAIL err_enter: got err=%b locked=%b err_cnt=%0d required 1/0/1", err, locked, err_cnt);
      end
      feed(4'd8);
      n_cmp++;
      if (err_cnt !== 8'd1) begin n_bad++; $display("FAIL err_match_ignored: got %0d required 1", err_cnt); end
      feed(4'd10);
      n_cmp++;
      if ({err, err_cnt} !== {1'b1, 8'd2}) begin n_bad++; $display("FAIL err_second: got err=%b cnt=%0d required 1/2", err, err_cnt); end
      feed(4'd0);
      n_cmp++;
      if ({err_cnt, restart, locked} !== {8'd3, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL err_rst_evt: got cnt=%0d restart=%b locked=%b required 3/0/0", err_cnt, restart, locked);
      end
`ifdef COUNT_SEQUENCE_CHECKER_CAPTURE_EN
      n_cmp++;
      if ({cap_exp, cap_act} !== {4'd6, 4'd7}) begin
         n_bad++; $display("FAIL capture_hold: got exp=%0d act=%0d required 6/7", cap_exp, cap_act);
      end
`endif
   endtask

   task automatic test_clr();
      step(4'd5, 1'b1, 1'b1);
      n_cmp++;
      if ({locked, err, restart, wrap_cnt, err_cnt} !== 19'd0) begin
         n_bad++; $display("FAIL clr_outputs: got %b required 0", {locked, err, restart, wrap_cnt, err_cnt});
      end
`ifdef COUNT_SEQUENCE_CHECKER_CAPTURE_EN
      n_cmp++;
      if ({cap_exp, cap_act} !== 8'd0) begin n_bad++; $display("FAIL clr_capture: got %0d/%0d required 0/0", cap_exp, cap_act); end
`endif
      feed(4'd1);
      feed(4'd2);
      n_cmp++;
      if (locked !== 1'b0) begin n_bad++; $display("FAIL clr_idle_sync: got %b required 0", locked); end
      feed(4'd3);
      n_cmp++;
      if ({locked, err} !== 2'b10) begin n_bad++; $display("FAIL clr_relock: got %b required 10", {locked, err}); end
   endtask

   task automatic test_async_reset();
      feed_run(4, 13);
      feed(4'd1); feed(4'd2); feed(4'd0);
      n_cmp++;
      if ({restart, wrap_cnt} !== {1'b1, 8'd1}) begin
         n_bad++; $display("FAIL pre_async: got restart=%b wrap=%0d required 1/1", restart, wrap_cnt);
      end
      #2;
      rstn = 1'b0;
      #1;
      n_cmp++;
      if ({locked, err, restart, wrap_cnt, err_cnt} !== 19'd0) begin
         n_bad++; $display("FAIL async_reset: got %b required 0", {locked, err, restart, wrap_cnt, err_cnt});
      end
      @(negedge clk);
      rstn = 1'b1;
      feed(4'd0); feed(4'd1);
      n_cmp++;
      if (locked !== 1'b0) begin n_bad++; $display("FAIL post_reset_sync: got %b required 0", locked); end
      feed(4'd2);
      n_cmp++;
      if (locked !== 1'b1) begin n_bad++; $display("FAIL post_reset_lock: got %b required 1", locked); end
   endtask

   task automatic test_saturation();
      feed_run(3, 4800);
      n_cmp++;
      if ({wrap_cnt, err, locked} !== {8'd255, 1'b0, 1'b1}) begin
         n_bad++; $display("FAIL wrap_saturate: got wrap=%0d err=%b locked=%b required 255/0/1", wrap_cnt, err, locked);
      end
   endtask

   task automatic test_valid_low();
      for (int i = 0; i < 20; i++) begin
         step(CNT_W'($urandom_range(0, 15)), 1'b0, 1'b0);
         n_cmp++;
         if ({locked, err, restart, wrap_cnt, err_cnt} !== {3'b100, 8'd255, 8'd0}) begin
            n_bad++; $display("FAIL valid_low_hold[%0d]: got %b required %b", i,
                              {locked, err, restart, wrap_cnt, err_cnt}, {3'b100, 8'd255, 8'd0});
         end
      end
      feed(4'd3);
      n_cmp++;
      if ({locked, err} !== 2'b10) begin n_bad++; $display("FAIL valid_low_resume: got %b required 10", {locked, err}); end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_wrap();
      test_restart();
      test_error();
      test_clr();
      test_async_reset();
      test_saturation();
      test_valid_low();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
